// File: rtl/sort4_seq.sv
// Sequential 4-entry sorter: serial load, 5 compare-exchange steps on one comparator, serial sorted output.
// Define SORT4_SEQ_DESC_EN to sort in descending order instead of ascending.
module sort4_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] r [4];
    logic [1:0]       cnt;
    logic [2:0]       step;
    logic [1:0]       idx_a;
    logic [1:0]       idx_b;
    logic             do_swap;
    logic             in_fire;
    logic             out_fire;

    // All handshake outputs decode registered state only.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (cnt == 2'd3);
    assign out_data  = r[cnt];
    assign busy      = (state != LOAD);

    assign in_fire  = in_valid  && in_ready;
    assign out_fire = out_valid && out_ready;

    // Same pair sequence as the combinational 4-input network.
    always_comb begin
        idx_a = 2'd1;
        idx_b = 2'd2;
        case (step)
            3'd0: begin idx_a = 2'd0; idx_b = 2'd2; end
            3'd1: begin idx_a = 2'd1; idx_b = 2'd3; end
            3'd2: begin idx_a = 2'd0; idx_b = 2'd1; end
            3'd3: begin idx_a = 2'd2; idx_b = 2'd3; end
            default: begin idx_a = 2'd1; idx_b = 2'd2; end
        endcase
    end

`ifdef SORT4_SEQ_DESC_EN
    assign do_swap = (r[idx_a] < r[idx_b]);
`else
    assign do_swap = (r[idx_a] > r[idx_b]);
`endif

    always_comb begin
        state_next = state;
        case (state)
            LOAD: if (in_fire && cnt == 2'd3) state_next = SORT;
            SORT: if (step == 3'd4) state_next = SEND;
            SEND: if (out_fire && cnt == 2'd3) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r    <= '{default: '0};
            cnt  <= '0;
            step <= '0;
        end else begin
            case (state)
                LOAD: begin
                    step <= '0;
                    if (in_fire) begin
                        r[cnt] <= in_data;
                        cnt    <= cnt + 2'd1;
                    end
                end
                SORT: begin
                    cnt <= '0;
                    if (do_swap) begin
                        r[idx_a] <= r[idx_b];
                        r[idx_b] <= r[idx_a];
                    end
                    step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
                end
                SEND: begin
                    if (out_fire) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                    cnt  <= '0;
                    step <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_seq.sv
// Directed bench for sort4_seq: load/sort/send timing, duplicates, backpressure, ignored input, reset abort.
module tb_sort4_seq;

    localparam int unsigned WIDTH = 4;
`ifdef SORT4_SEQ_DESC_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    sort4_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Expected values given ascending; descending build reads them reversed.
    task automatic pop4(input string tag, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                        input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3);
        logic [WIDTH-1:0] e [4];
        e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
        for (int i = 0; i < 4; i++) begin
            int unsigned t = 0;
            out_ready = 1'b1;
            while (!out_valid && t < 50) begin
                tick();
                t++;
            end
            if (!out_valid) check({tag, "_pop_timeout"}, 32'(out_valid), 32'd1);
            check($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(DESC ? e[3-i] : e[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(out_last), 32'(i == 3));
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Basic batch with latency check: SORT for 5 cycles, out_valid on the 6th.
        push(4'h9); push(4'h3); push(4'hF); push(4'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lat_out_valid%0d", i), 32'(out_valid), 32'd0);
            check($sformatf("lat_busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("lat_in_ready%0d", i), 32'(in_ready), 32'd0);
            tick();
        end
        check("lat_first_valid", 32'(out_valid), 32'd1);
        pop4("basic", 4'h0, 4'h3, 4'h9, 4'hF);

        push(4'h5); push(4'h5); push(4'h2); push(4'h5);
        pop4("dup", 4'h2, 4'h5, 4'h5, 4'h5);

        push(4'h7); push(4'h7); push(4'h7); push(4'h7);
        pop4("equal", 4'h7, 4'h7, 4'h7, 4'h7);

        // Gapped input, then stall the consumer on the first element.
        push(4'h1); tick(); push(4'hE); tick(); push(4'h4); tick(); push(4'h8);
        for (int i = 0; i < 8 && !out_valid; i++) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_data%0d", i), 32'(out_data), DESC ? 32'hE : 32'h1);
            check($sformatf("bp_last%0d", i), 32'(out_last), 32'd0);
            tick();
        end
        pop4("bp", 4'h1, 4'h4, 4'h8, 4'hE);

        // in_valid held with stray data through SORT and the start of SEND.
        push(4'hC); push(4'h6); push(4'hB); in_valid = 1'b1; in_data = 4'h6;
        tick();
        in_data = 4'hA;
        for (int i = 0; i < 7; i++) tick();
        check("ign_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        pop4("ign", 4'h6, 4'h6, 4'hB, 4'hC);
        push(4'h2); push(4'hD); push(4'h0); push(4'h9);
        pop4("after_ign", 4'h0, 4'h2, 4'h9, 4'hD);

        // Reset during SORT step2 discards the batch.
        push(4'hF); push(4'hE); push(4'hD); push(4'hC);
        tick(); tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        push(4'h3); push(4'h2); push(4'h1); push(4'h0);
        pop4("post_rst", 4'h0, 4'h1, 4'h2, 4'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
